// File: rtl/host_rx_timer_pkg.sv
// host_rx_timer_pkg
// Shared constants and types for the host receive timer bank.
//   TIMER_W_DEF    : default counter width per channel
//   DEFAULT_TC_DEF : default reset terminal count (4 ms at 125 MHz)
//   WRAPCNT_W_DEF  : default wrap-counter width
//   CH_NUM_MAX     : largest supported channel count
//   ch_action_e    : per-channel action selected on each clock
package host_rx_timer_pkg;

  localparam int          TIMER_W_DEF    = 19;
  localparam int unsigned DEFAULT_TC_DEF = 499999;
  localparam int          WRAPCNT_W_DEF  = 16;
  localparam int          CH_NUM_MAX     = 16;

  // Priority-resolved action of one channel for the current clock.
  typedef enum logic [1:0] {
    CH_COUNT = 2'd0,
    CH_HOLD  = 2'd1,
    CH_WRAP  = 2'd2,
    CH_CLEAR = 2'd3
  } ch_action_e;

endpackage

// File: rtl/host_rx_timer_ch.sv
// host_rx_timer_ch
// One free-running timer channel: counts 0..active_tc, wraps with a
// one-cycle pulse, adopts the shared shadow terminal count on wrap or clear.
// Optional wrap counter enabled by HOST_RX_TIMER_WRAP_CNT_EN.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clr            synchronous clear of this channel
//   i_freeze         hold the count
//   i_tc_wr          shadow write strobe (re-arms the pending bit)
//   iv_shadow        shadow terminal count as registered before this edge
//   ov_count         current count
//   o_wrap_pulse     one-cycle natural-wrap flag
//   ov_active_tc     terminal count in use
//   o_pending        shadow not yet adopted by this channel
//   ov_wrap_cnt      number of wraps (macro only)
module host_rx_timer_ch
  import host_rx_timer_pkg::*;
#(
  parameter int          TIMER_W    = TIMER_W_DEF,
  parameter int unsigned DEFAULT_TC = DEFAULT_TC_DEF
`ifdef HOST_RX_TIMER_WRAP_CNT_EN
  ,
  parameter int          WRAPCNT_W  = WRAPCNT_W_DEF
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_freeze,
  input  logic               i_tc_wr,
  input  logic [TIMER_W-1:0] iv_shadow,
  output logic [TIMER_W-1:0] ov_count,
  output logic               o_wrap_pulse,
  output logic [TIMER_W-1:0] ov_active_tc,
  output logic               o_pending
`ifdef HOST_RX_TIMER_WRAP_CNT_EN
  ,
  output logic [WRAPCNT_W-1:0] ov_wrap_cnt
`endif
);

  localparam logic [TIMER_W-1:0] TC_RST = TIMER_W'(DEFAULT_TC);

  logic [TIMER_W-1:0] r_count;
  logic [TIMER_W-1:0] r_active_tc;
  logic               r_pulse;
  logic               r_pending;
  ch_action_e         w_action;
  logic               w_adopt;

  // Clear beats freeze, freeze beats wrap. The count never exceeds
  // r_active_tc (a lower TC is only adopted together with count=0),
  // so the equality compare is enough to bound it.
  always_comb begin
    w_action = CH_COUNT;
    if (i_clr) begin
      w_action = CH_CLEAR;
    end else if (i_freeze) begin
      w_action = CH_HOLD;
    end else if (r_count == r_active_tc) begin
      w_action = CH_WRAP;
    end
  end

  assign w_adopt = (w_action == CH_CLEAR) || (w_action == CH_WRAP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= '0;
      r_active_tc <= TC_RST;
      r_pulse     <= 1'b0;
    end else begin
      case (w_action)
        CH_CLEAR: begin
          r_count     <= '0;
          r_active_tc <= iv_shadow;
          r_pulse     <= 1'b0;
        end
        CH_HOLD: begin
          r_pulse     <= 1'b0;
        end
        CH_WRAP: begin
          r_count     <= '0;
          r_active_tc <= iv_shadow;
          r_pulse     <= 1'b1;
        end
        default: begin
          r_count     <= r_count + TIMER_W'(1);
          r_pulse     <= 1'b0;
        end
      endcase
    end
  end

  // A write on the same edge as an adoption wins: the channel took the
  // old shadow, so the new one is still outstanding for it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
    end else if (i_tc_wr) begin
      r_pending <= 1'b1;
    end else if (w_adopt) begin
      r_pending <= 1'b0;
    end
  end

`ifdef HOST_RX_TIMER_WRAP_CNT_EN
  logic [WRAPCNT_W-1:0] r_wrap_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrap_cnt <= '0;
    end else if (w_action == CH_CLEAR) begin
      r_wrap_cnt <= '0;
    end else if (w_action == CH_WRAP) begin
      r_wrap_cnt <= r_wrap_cnt + WRAPCNT_W'(1);
    end
  end

  assign ov_wrap_cnt = r_wrap_cnt;
`endif

  assign ov_count     = r_count;
  assign o_wrap_pulse = r_pulse;
  assign ov_active_tc = r_active_tc;
  assign o_pending    = r_pending;

endmodule

// File: rtl/host_rx_timer_bank.sv
// host_rx_timer_bank
// Bank of CH_NUM independent free-running cycle timers for the host
// receive path. Holds the shared shadow terminal-count register and
// instantiates one host_rx_timer_ch per channel.
// Optional feature macro: HOST_RX_TIMER_WRAP_CNT_EN adds ov_wrap_cnt.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   iv_timer_rst     per-channel synchronous clear
//   i_freeze         hold all counters
//   i_tc_wr, iv_tc   shadow terminal-count write
//   ov_timer         channel c count at [c*TIMER_W +: TIMER_W]
//   ov_wrap_pulse    one-cycle natural-wrap flag per channel
//   ov_active_tc     terminal count in use per channel
//   o_tc_pending     shadow not yet adopted by every channel
//   ov_wrap_cnt      wraps per channel (macro only)
module host_rx_timer_bank
  import host_rx_timer_pkg::*;
#(
  parameter int          CH_NUM     = 4,
  parameter int          TIMER_W    = TIMER_W_DEF,
  parameter int unsigned DEFAULT_TC = DEFAULT_TC_DEF,
  parameter int          WRAPCNT_W  = WRAPCNT_W_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CH_NUM-1:0]         iv_timer_rst,
  input  logic                      i_freeze,
  input  logic                      i_tc_wr,
  input  logic [TIMER_W-1:0]        iv_tc,
  output logic [CH_NUM*TIMER_W-1:0] ov_timer,
  output logic [CH_NUM-1:0]         ov_wrap_pulse,
  output logic [CH_NUM*TIMER_W-1:0] ov_active_tc,
  output logic                      o_tc_pending
`ifdef HOST_RX_TIMER_WRAP_CNT_EN
  ,
  output logic [CH_NUM*WRAPCNT_W-1:0] ov_wrap_cnt
`endif
);

  localparam logic [TIMER_W-1:0] TC_RST = TIMER_W'(DEFAULT_TC);

  // Elaboration-time parameter sanity.
  if (CH_NUM < 1 || CH_NUM > CH_NUM_MAX) begin : g_bad_ch_num
    $error("host_rx_timer_bank: CH_NUM out of range");
  end
  if ((64'(DEFAULT_TC) >> TIMER_W) != 64'd0) begin : g_bad_default_tc
    $error("host_rx_timer_bank: DEFAULT_TC does not fit in TIMER_W");
  end
  if (WRAPCNT_W < 1) begin : g_bad_wrapcnt_w
    $error("host_rx_timer_bank: WRAPCNT_W must be at least 1");
  end

  logic [TIMER_W-1:0] r_shadow;
  logic [CH_NUM-1:0]  w_pending;

  // Channels see the shadow as it was before this edge, so a write and
  // an adoption on the same edge hand over the previous value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= TC_RST;
    end else if (i_tc_wr) begin
      r_shadow <= iv_tc;
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    host_rx_timer_ch #(
      .TIMER_W    (TIMER_W),
      .DEFAULT_TC (DEFAULT_TC)
`ifdef HOST_RX_TIMER_WRAP_CNT_EN
      ,
      .WRAPCNT_W  (WRAPCNT_W)
`endif
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clr        (iv_timer_rst[c]),
      .i_freeze     (i_freeze),
      .i_tc_wr      (i_tc_wr),
      .iv_shadow    (r_shadow),
      .ov_count     (ov_timer[c*TIMER_W +: TIMER_W]),
      .o_wrap_pulse (ov_wrap_pulse[c]),
      .ov_active_tc (ov_active_tc[c*TIMER_W +: TIMER_W]),
      .o_pending    (w_pending[c])
`ifdef HOST_RX_TIMER_WRAP_CNT_EN
      ,
      .ov_wrap_cnt  (ov_wrap_cnt[c*WRAPCNT_W +: WRAPCNT_W])
`endif
    );
  end

  assign o_tc_pending = |w_pending;

endmodule

// File: tb/tb_host_rx_timer_bank.sv
// tb_host_rx_timer_bank
// Directed bench for host_rx_timer_bank with CH_NUM=4, TIMER_W=8,
// DEFAULT_TC=9, WRAPCNT_W=4. Inputs change and outputs are sampled 1 ns
// after each rising edge.
module tb_host_rx_timer_bank;

  localparam int CH_NUM    = 4;
  localparam int TIMER_W   = 8;
  localparam int WRAPCNT_W = 4;

  logic                      clk;
  logic                      rst_n;
  logic [CH_NUM-1:0]         timer_rst;
  logic                      freeze;
  logic                      tc_wr;
  logic [TIMER_W-1:0]        tc;
  logic [CH_NUM*TIMER_W-1:0] timer;
  logic [CH_NUM-1:0]         wrap_pulse;
  logic [CH_NUM*TIMER_W-1:0] active_tc;
  logic                      tc_pending;
`ifdef HOST_RX_TIMER_WRAP_CNT_EN
  logic [CH_NUM*WRAPCNT_W-1:0] wrap_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [TIMER_W-1:0] exp_q[$];

  host_rx_timer_bank #(
    .CH_NUM     (CH_NUM),
    .TIMER_W    (TIMER_W),
    .DEFAULT_TC (9),
    .WRAPCNT_W  (WRAPCNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .iv_timer_rst  (timer_rst),
    .i_freeze      (freeze),
    .i_tc_wr       (tc_wr),
    .iv_tc         (tc),
    .ov_timer      (timer),
    .ov_wrap_pulse (wrap_pulse),
    .ov_active_tc  (active_tc),
    .o_tc_pending  (tc_pending)
`ifdef HOST_RX_TIMER_WRAP_CNT_EN
    ,
    .ov_wrap_cnt   (wrap_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TIMER_W-1:0] tmr(input int c);
    return timer[c*TIMER_W +: TIMER_W];
  endfunction

  function automatic logic [TIMER_W-1:0] atc(input int c);
    return active_tc[c*TIMER_W +: TIMER_W];
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    timer_rst = '0;
    freeze    = 1'b0;
    tc_wr     = 1'b0;
    tc        = '0;
    steps(3);

    // reset state
    chk("rst_timer", 32'(timer), 32'd0);
    chk("rst_pulse", 32'(wrap_pulse), 32'd0);
    chk("rst_atc0", 32'(atc(0)), 32'd9);
    chk("rst_atc3", 32'(atc(3)), 32'd9);
    chk("rst_pending", 32'(tc_pending), 32'd0);
    rst_n = 1'b1;

    // free run 0..9 then wrap: scoreboard of expected ch0 counts
    for (int k = 1; k <= 12; k++) exp_q.push_back(TIMER_W'(k % 10));
    for (int k = 1; k <= 12; k++) begin
      logic [TIMER_W-1:0] e;
      step();
      e = exp_q.pop_front();
      chk("run_cnt0", 32'(tmr(0)), 32'(e));
      chk("run_cnt3", 32'(tmr(3)), 32'(e));
      chk("run_pulse", 32'(wrap_pulse), (e == 0) ? 32'hF : 32'h0);
    end

    // clear channel 1 at count 5
    steps(3);
    chk("pre_clr_cnt", 32'(tmr(1)), 32'd5);
    timer_rst = 4'b0010;
    step();
    timer_rst = '0;
    chk("clr_ch1", 32'(tmr(1)), 32'd0);
    chk("clr_ch0", 32'(tmr(0)), 32'd6);
    chk("clr_nopulse", 32'(wrap_pulse), 32'd0);

    // write tc=3 while ch0 is at 7
    step();
    tc_wr = 1'b1;
    tc    = 8'd3;
    step();
    tc_wr = 1'b0;
    chk("wr_pending", 32'(tc_pending), 32'd1);
    chk("wr_atc0_old", 32'(atc(0)), 32'd9);
    chk("wr_cnt0", 32'(tmr(0)), 32'd8);
    steps(2);
    chk("wr_wrap_cnt0", 32'(tmr(0)), 32'd0);
    chk("wr_wrap_pulse", 32'(wrap_pulse), 32'hD);
    chk("wr_atc0_new", 32'(atc(0)), 32'd3);
    chk("wr_cnt1", 32'(tmr(1)), 32'd4);
    steps(4);
    chk("tc3_wrap_cnt0", 32'(tmr(0)), 32'd0);
    chk("tc3_wrap_pulse", 32'(wrap_pulse), 32'hD);
    chk("tc3_pending", 32'(tc_pending), 32'd1);
    steps(2);
    chk("ch1_wrap_cnt", 32'(tmr(1)), 32'd0);
    chk("ch1_wrap_pulse", 32'(wrap_pulse), 32'h2);
    chk("ch1_pending_done", 32'(tc_pending), 32'd0);
    chk("ch1_atc", 32'(atc(1)), 32'd3);

    // write tc=4 on the same edge as ch0's wrap
    step();
    chk("pre_same_cnt0", 32'(tmr(0)), 32'd3);
    tc_wr = 1'b1;
    tc    = 8'd4;
    step();
    tc_wr = 1'b0;
    chk("same_cnt0", 32'(tmr(0)), 32'd0);
    chk("same_pulse0", 32'(wrap_pulse[0]), 32'd1);
    chk("same_atc0_old", 32'(atc(0)), 32'd3);
    chk("same_pending", 32'(tc_pending), 32'd1);
    steps(2);
    chk("same_ch1_atc", 32'(atc(1)), 32'd4);
    step();
    chk("same_pending_hold", 32'(tc_pending), 32'd1);
    chk("same_atc0_still", 32'(atc(0)), 32'd3);
    step();
    chk("same_atc0_new", 32'(atc(0)), 32'd4);
    chk("same_pending_done", 32'(tc_pending), 32'd0);

    // back to tc=9 via write + clear of all channels
    tc_wr = 1'b1;
    tc    = 8'd9;
    step();
    tc_wr     = 1'b0;
    timer_rst = 4'hF;
    step();
    timer_rst = '0;
    chk("reload_timer", 32'(timer), 32'd0);
    chk("reload_atc2", 32'(atc(2)), 32'd9);
    chk("reload_pending", 32'(tc_pending), 32'd0);
    chk("reload_nopulse", 32'(wrap_pulse), 32'd0);

    // freeze at 9
    steps(9);
    chk("frz_pre", 32'(tmr(0)), 32'd9);
    freeze = 1'b1;
    step();
    chk("frz_hold1", 32'(tmr(0)), 32'd9);
    chk("frz_nopulse1", 32'(wrap_pulse), 32'd0);
    steps(4);
    chk("frz_hold5", 32'(tmr(2)), 32'd9);
    chk("frz_nopulse5", 32'(wrap_pulse), 32'd0);
    freeze = 1'b0;
    step();
    chk("frz_wrap", 32'(tmr(0)), 32'd0);
    chk("frz_wrap_pulse", 32'(wrap_pulse), 32'hF);
    step();
    freeze = 1'b1;
    step();
    chk("frz2_hold", 32'(tmr(0)), 32'd1);
    timer_rst = 4'b0001;
    step();
    timer_rst = '0;
    chk("frz_clr_ch0", 32'(tmr(0)), 32'd0);
    chk("frz_clr_ch1", 32'(tmr(1)), 32'd1);
    chk("frz_clr_nopulse", 32'(wrap_pulse), 32'd0);
    freeze = 1'b0;

    // terminal count 0
    tc_wr = 1'b1;
    tc    = 8'd0;
    step();
    tc_wr     = 1'b0;
    timer_rst = 4'hF;
    step();
    timer_rst = '0;
    chk("tc0_atc", 32'(atc(3)), 32'd0);
    chk("tc0_clr_nopulse", 32'(wrap_pulse), 32'd0);
    step();
    chk("tc0_cnt", 32'(timer), 32'd0);
    chk("tc0_pulse1", 32'(wrap_pulse), 32'hF);
    step();
    chk("tc0_pulse2", 32'(wrap_pulse), 32'hF);
    freeze = 1'b1;
    step();
    chk("tc0_frz_nopulse", 32'(wrap_pulse), 32'd0);
    freeze = 1'b0;

`ifdef HOST_RX_TIMER_WRAP_CNT_EN
    // wrap counter: clear, then 15 wraps, then roll over to 0
    timer_rst = 4'hF;
    step();
    timer_rst = '0;
    chk("wcnt_clr", 32'(wrap_cnt), 32'd0);
    steps(15);
    chk("wcnt_15", 32'(wrap_cnt[3:0]), 32'd15);
    step();
    chk("wcnt_roll", 32'(wrap_cnt[3:0]), 32'd0);
    chk("wcnt_ch3", 32'(wrap_cnt[15:12]), 32'd0);
`endif

    // asynchronous reset mid-count
    tc_wr = 1'b1;
    tc    = 8'd9;
    step();
    tc_wr     = 1'b0;
    timer_rst = 4'hF;
    step();
    timer_rst = '0;
    steps(4);
    chk("pre_arst_cnt", 32'(tmr(0)), 32'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_timer", 32'(timer), 32'd0);
    chk("arst_atc", 32'(atc(1)), 32'd9);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_first_inc", 32'(tmr(0)), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
